// File: rtl/operand_serializer.sv
// Parallel-to-serial operand feeder: loads a WIDTH-bit operand and streams it LSB-first.
// Define OPERAND_SERIALIZER_ROTATE_EN to rotate (preserve operand) instead of zero-filling.
module operand_serializer #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_en,
    input  logic [WIDTH-1:0]         parallel_in,
    input  logic                     start,
    input  logic                     abort,
    output logic                     ser_out,
    output logic                     ser_valid,
    output logic [$clog2(WIDTH)-1:0] bit_index,
    output logic                     last_bit,
    output logic                     ready,
    output logic                     busy,
    output logic                     done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [CW-1:0]     idx_q,   idx_d;
    logic              fill;

`ifdef OPERAND_SERIALIZER_ROTATE_EN
    assign fill = shift_q[0];
`else
    assign fill = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (load_en) shift_d = parallel_in;
                if (start) begin
                    state_d = SHIFT;
                    idx_d   = '0;
                end
            end
            SHIFT: begin
                // The bit on ser_out this cycle is consumed even when aborting.
                shift_d = {fill, shift_q[WIDTH-1:1]};
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ser_valid = (state_q == SHIFT);
        busy      = (state_q == SHIFT);
        done      = (state_q == DONE);
        ready     = (state_q == IDLE);
        last_bit  = (state_q == SHIFT) && (idx_q == LAST_IDX);
    end

    assign ser_out   = shift_q[0];
    assign bit_index = idx_q;

endmodule

// File: doc/operand_serializer.md
Name: operand_serializer

Overview:
Parallel-to-serial operand feeder for the bit-serial datapath. It takes a WIDTH-bit operand by parallel load and, on start, presents it to the serial ALU one bit per clock, LSB-first, with a valid, index and last-bit strobe. It is the transmit-side counterpart of the accumulator, which collects ALU result bits serially. A one-cycle done pulse tells the controller that the operand has been fully streamed.

Parameters:
WIDTH, 8, operand width in bits; must be ≥2. Counter width is $clog2(WIDTH).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
load_en  input  1  parallel load of parallel_in; honoured only in IDLE
parallel_in  input  WIDTH  operand to serialize
start  input  1  begin streaming; honoured only in IDLE
abort  input  1  cancel streaming; honoured only in SHIFT
ser_out  output  1  current serial bit to ALU (= shift_reg[0])
ser_valid  output  1  high while ser_out carries an operand bit
bit_index  output  $clog2(WIDTH)  index of the bit currently on ser_out
last_bit  output  1  ser_valid && bit_index==WIDTH-1
ready  output  1  high in IDLE (load/start accepted)
busy  output  1  high in SHIFT
done  output  1  one-cycle pulse after the final bit

Behaviour:
- Reset (async, rst_n low): shift_reg=0, state=IDLE, bit_index=0. Outputs: ser_out=0, ser_valid=0, last_bit=0, busy=0, done=0, ready=1. Reset mid-stream aborts immediately; no done pulse.
- State machine: IDLE, SHIFT, DONE. State-derived outputs are decoded from registered state: ser_valid=busy=(state==SHIFT), done=(state==DONE), ready=(state==IDLE).
- IDLE:
  - load_en=1: shift_reg<=parallel_in.
  - start=1: state<=SHIFT, bit_index<=0.
  - load_en and start in the same cycle: both take effect; the first streamed bit is parallel_in[0].
- SHIFT:
  - Each cycle ser_out=shift_reg[0] with ser_valid=1.
  - At the clock edge: shift_reg shifts right by one (MSB fill per the optional feature); bit_index increments.
  - When bit_index==WIDTH-1 (last_bit=1): state<=DONE, bit_index<=0.
  - Exactly WIDTH valid cycles per start.
- DONE: done=1 for one cycle, then state<=IDLE unconditionally. start and load_en are ignored in this cycle.
- Latency: start sampled at edge N → bit 0 valid in cycle N+1, bit WIDTH-1 in cycle N+WIDTH, done in cycle N+WIDTH+1, ready again in cycle N+WIDTH+2.
- Ignored inputs:
  - start and load_en are ignored while in SHIFT or DONE; shift_reg is never overwritten mid-stream.
  - abort is ignored outside SHIFT.
- abort in SHIFT (including on the last_bit cycle): state<=IDLE, bit_index<=0, no done pulse. shift_reg keeps its partially shifted contents.
- bit_index wraps only via explicit clear; it never counts past WIDTH-1.
- ser_out is combinational from shift_reg[0] and is defined (non-X) in every state. Consumers qualify it with ser_valid.

Optional Feature:
Macro: OPERAND_SERIALIZER_ROTATE_EN.
- Defined: the shift is a rotate; shift_reg[0] re-enters at the MSB. After a complete WIDTH-bit stream, shift_reg equals the loaded operand again, so a second start with no reload re-streams the same value. An aborted stream leaves the operand rotated by the number of bits already sent.
- Undefined: zero fill at the MSB. After a complete stream, shift_reg=0, and a restart without reload streams zeros.

Test Plan:
- Reset → ser_out=0, ser_valid=0, busy=0, done=0, ready=1, bit_index=0. Assert rst_n low during SHIFT at bit 3 → all outputs return to reset values asynchronously; no done pulse.
- WIDTH=8: load 0xA5, then start → ser_out sequence 1,0,1,0,0,1,0,1 over 8 ser_valid cycles with bit_index 0..7. last_bit only on the 8th valid cycle, done on the 9th cycle, ready on the 10th.
- load_en=1 with parallel_in=0x3C and start=1 in the same IDLE cycle → stream 0,0,1,1,1,1,0,0.
- Load 0xFF and start. During SHIFT, pulse start and load_en with 0x00 → stream stays eight 1s, done once. Abort at bit_index=4 → IDLE next cycle, ser_valid=0, no done.
- Load 0xA5, stream to completion, start again with no reload:
  - With OPERAND_SERIALIZER_ROTATE_EN → second stream is 1,0,1,0,0,1,0,1.
  - Without → second stream is eight 0s.
